// File: rtl/mmio_bus_arbiter.sv
// mmio_bus_arbiter: two-master bus arbiter with bounded bursts, one-hot slave decode
// and a one-deep read-return pipeline that routes late slave data back to its issuer.
module mmio_bus_arbiter #(
  parameter logic [31:0] BRAM_BASE = 32'h0000_0000,
  parameter logic [31:0] BRAM_TOP  = 32'h0000_01FF,
  parameter logic [31:0] GPIO_BASE = 32'hFFFF_FFF0,
  parameter logic [31:0] GPIO_TOP  = 32'hFFFF_FFF3,
  parameter logic [31:0] UART_BASE = 32'hFFFF_FFF4,
  parameter logic [31:0] UART_TOP  = 32'hFFFF_FFF7,
  parameter int          MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0Req,
  input  logic        m1Req,
  input  logic [31:0] m0Address,
  input  logic [31:0] m1Address,
  input  logic [31:0] m0WriteData,
  input  logic [31:0] m1WriteData,
  input  logic        m0Write,
  input  logic        m1Write,
  input  logic [3:0]  m0ByteMask,
  input  logic [3:0]  m1ByteMask,
  output logic        m0Gnt,
  output logic        m1Gnt,
  output logic        m0Done,
  output logic        m1Done,
  output logic [31:0] m0ReadData,
  output logic [31:0] m1ReadData,
  output logic [31:0] slvAddress,
  output logic [31:0] slvWriteData,
  output logic [3:0]  slvByteMask,
  output logic        slvWrite,
  output logic [2:0]  slvSel,
  input  logic [31:0] bramReadData,
  input  logic [31:0] gpioReadData,
  input  logic [31:0] uartReadData,
  output logic        decodeErr
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN0 = 2'd1;
  localparam logic [1:0] OWN1 = 2'd2;
  localparam logic [3:0] MB = 4'(MAX_BURST);
  logic [1:0] state_q, state_d, oth_st;
  logic [3:0] burst_q, burst_d, cnt;
  logic last_q, last_d;
  logic rd_valid_q, rd_owner_q, rd_write_q;
  logic [2:0] rd_sel_q, sel;
  logic own, owner, own_req, oth_req, acc, wr;
  logic [31:0] rd_data;
  // Offset compare keeps windows inclusive without a constant-zero lower bound check.
  function automatic logic in_win(logic [31:0] a, logic [31:0] b, logic [31:0] t);
    return (a - b) <= (t - b);
  endfunction
  assign own = state_q != IDLE;
  assign owner = state_q == OWN1;
  assign own_req = owner ? m1Req : m0Req;
  assign oth_req = owner ? m0Req : m1Req;
  assign acc = own & own_req;
  assign wr = owner ? m1Write : m0Write;
  assign oth_st = owner ? OWN0 : OWN1;
  assign m0Gnt = state_q == OWN0;
  assign m1Gnt = state_q == OWN1;
  assign slvAddress = own ? (owner ? m1Address : m0Address) : '0;
  assign slvWriteData = own ? (owner ? m1WriteData : m0WriteData) : '0;
  assign slvByteMask = own ? (owner ? m1ByteMask : m0ByteMask) : '0;
  assign sel = in_win(slvAddress, BRAM_BASE, BRAM_TOP) ? 3'b001 :
               in_win(slvAddress, GPIO_BASE, GPIO_TOP) ? 3'b010 :
               in_win(slvAddress, UART_BASE, UART_TOP) ? 3'b100 : 3'b000;
  assign slvSel = acc ? sel : 3'b000;
  assign slvWrite = acc & wr & (|sel);
  // Saturate at the limit so a long uncontested burst hands over as soon as the other asks.
  assign cnt = burst_q + {3'b000, acc && burst_q != MB};
  assign state_d = !own ? ((m0Req & m1Req) ? (last_q ? OWN0 : OWN1) :
                           m0Req ? OWN0 : m1Req ? OWN1 : IDLE) :
                   !own_req ? (oth_req ? oth_st : IDLE) :
                   (oth_req && cnt >= MB) ? oth_st : state_q;
  assign burst_d = state_d != state_q ? 4'd0 : cnt;
  assign last_d = (own && state_d != state_q) ? owner : last_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      burst_q <= '0;
      last_q <= 1'b1;
      rd_valid_q <= 1'b0;
      rd_owner_q <= 1'b0;
      rd_write_q <= 1'b0;
      rd_sel_q <= '0;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
      last_q <= last_d;
      rd_valid_q <= acc;
      rd_owner_q <= owner;
      rd_write_q <= wr;
      rd_sel_q <= slvSel;
    end
  end
  assign rd_data = rd_write_q ? '0 : rd_sel_q[0] ? bramReadData :
                   rd_sel_q[1] ? gpioReadData : rd_sel_q[2] ? uartReadData : '0;
  assign m0Done = rd_valid_q & ~rd_owner_q;
  assign m1Done = rd_valid_q & rd_owner_q;
  assign m0ReadData = m0Done ? rd_data : '0;
  assign m1ReadData = m1Done ? rd_data : '0;
  assign decodeErr = rd_valid_q & ~(|rd_sel_q);
endmodule

// File: tb/tb_mmio_bus_arbiter.sv
// tb_mmio_bus_arbiter: directed and random stimulus against a cycle-level behavioural
// model of ownership, burst fairness, address decode and read return.
module tb_mmio_bus_arbiter;
  localparam int MAXB = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  logic [1:0] req = '0, wr = '0;
  logic [1:0][31:0] addr = '0, wd = '0;
  logic [1:0][3:0] bm = '0;
  logic [31:0] bram_rd = '0, gpio_rd = '0, uart_rd = '0;
  logic g0, g1, d0, d1, slv_wr, derr;
  logic [31:0] r0, r1, slv_addr, slv_wd;
  logic [3:0] slv_bm;
  logic [2:0] slv_sel;
  int checks = 0, errors = 0;
  int own = -1, cnt = 0, last = 1, po = 0;
  bit pv = 0, pw = 0;
  logic [2:0] psel = '0;

  mmio_bus_arbiter dut (
    .clk(clk), .reset(reset),
    .m0Req(req[0]), .m1Req(req[1]),
    .m0Address(addr[0]), .m1Address(addr[1]),
    .m0WriteData(wd[0]), .m1WriteData(wd[1]),
    .m0Write(wr[0]), .m1Write(wr[1]),
    .m0ByteMask(bm[0]), .m1ByteMask(bm[1]),
    .m0Gnt(g0), .m1Gnt(g1), .m0Done(d0), .m1Done(d1),
    .m0ReadData(r0), .m1ReadData(r1),
    .slvAddress(slv_addr), .slvWriteData(slv_wd), .slvByteMask(slv_bm),
    .slvWrite(slv_wr), .slvSel(slv_sel),
    .bramReadData(bram_rd), .gpioReadData(gpio_rd), .uartReadData(uart_rd),
    .decodeErr(derr)
  );

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got=%h exp=%h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [2:0] dec(logic [31:0] a);
    if (a <= 32'h0000_01FF) return 3'b001;
    if (a >= 32'hFFFF_FFF0 && a <= 32'hFFFF_FFF3) return 3'b010;
    if (a >= 32'hFFFF_FFF4 && a <= 32'hFFFF_FFF7) return 3'b100;
    return 3'b000;
  endfunction

  function automatic logic [31:0] pick_addr();
    case ($urandom_range(0, 9))
      0: return 32'($urandom_range(0, 511));
      1: return 32'h0000_01FF;
      2: return 32'h0000_0200;
      3: return 32'hFFFF_FFF0 + 32'($urandom_range(0, 3));
      4: return 32'hFFFF_FFF4 + 32'($urandom_range(0, 3));
      5: return 32'hFFFF_FFEF;
      6: return 32'hFFFF_FFF8;
      7: return $urandom;
      8: return 32'h0000_0000;
      default: return 32'hFFFF_FFF7;
    endcase
  endfunction

  // Compare every output against the model, then advance the model and the clock.
  task automatic tick();
    bit acc, ew;
    int nxt, o;
    logic [2:0] es;
    logic [31:0] pdata, ea, ed;
    logic [3:0] eb;
    @(negedge clk);
    acc = own >= 0 ? req[own] : 1'b0;
    ea = own >= 0 ? addr[own] : '0;
    ed = own >= 0 ? wd[own] : '0;
    eb = own >= 0 ? bm[own] : '0;
    es = acc ? dec(ea) : 3'b000;
    ew = acc && wr[own] && es != 0;
    pdata = psel == 3'b001 ? bram_rd : psel == 3'b010 ? gpio_rd : psel == 3'b100 ? uart_rd : '0;
    check("m0Gnt", 32'(g0), 32'(own == 0));
    check("m1Gnt", 32'(g1), 32'(own == 1));
    check("slvAddress", slv_addr, ea);
    check("slvWriteData", slv_wd, ed);
    check("slvByteMask", 32'(slv_bm), 32'(eb));
    check("slvSel", 32'(slv_sel), 32'(es));
    check("slvWrite", 32'(slv_wr), 32'(ew));
    check("m0Done", 32'(d0), 32'(pv && po == 0));
    check("m1Done", 32'(d1), 32'(pv && po == 1));
    check("m0ReadData", r0, (pv && po == 0 && !pw) ? pdata : 32'h0);
    check("m1ReadData", r1, (pv && po == 1 && !pw) ? pdata : 32'h0);
    check("decodeErr", 32'(derr), 32'(pv && psel == 0));
    if (reset) begin
      own = -1; cnt = 0; last = 1; pv = 0;
    end else begin
      pv = acc; po = own; pw = acc && wr[own]; psel = es;
      nxt = own;
      if (own < 0) nxt = (req[0] && req[1]) ? 1 - last : req[0] ? 0 : req[1] ? 1 : -1;
      else begin
        o = 1 - own;
        if (acc) cnt++;
        if (!req[own]) nxt = req[o] ? o : -1;
        else if (req[o] && cnt >= MAXB) nxt = o;
      end
      if (nxt != own) begin
        if (own >= 0) last = own;
        cnt = 0;
      end
      own = nxt;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(int m, bit r, bit w, logic [31:0] a, logic [31:0] d, logic [3:0] b);
    req[m] = r; wr[m] = w; addr[m] = a; wd[m] = d; bm[m] = b;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    drive(0, 1, 0, 32'h40, 32'h0, 4'hF);
    drive(1, 1, 0, 32'h80, 32'h0, 4'hF);
    repeat (2) tick();
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bram_rd = $urandom;
      tick();
    end
    req = '0;
    repeat (3) tick();
    drive(0, 1, 0, 32'h10, 32'h0, 4'hF);
    bram_rd = 32'hDEAD_BEEF;
    tick();
    tick();
    req = '0;
    repeat (2) tick();
    drive(1, 1, 1, 32'hFFFF_FFF0, 32'h1, 4'b0001);
    tick();
    tick();
    drive(1, 1, 1, 32'h0000_1000, 32'h5, 4'hF);
    tick();
    req = '0;
    repeat (2) tick();
    drive(1, 1, 0, 32'hFFFF_FFF4, 32'h0, 4'hF);
    uart_rd = 32'h1234_5678;
    repeat (2) tick();
    reset = 1'b1;
    req = '0;
    tick();
    reset = 1'b0;
    repeat (2) tick();
    for (int i = 0; i < 800; i++) begin
      for (int m = 0; m < 2; m++)
        drive(m, $urandom_range(0, 3) != 0, 1'($urandom), pick_addr(), $urandom, 4'($urandom));
      bram_rd = $urandom;
      gpio_rd = $urandom;
      uart_rd = $urandom;
      reset = $urandom_range(0, 60) == 0;
      tick();
    end
    reset = 1'b0;
    req = '0;
    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
